ps2_kbd_events: RTL and testbench
=================================

PS2_KBD_EVENTS -- requirements
Module: ps2_kbd_events

Interface
REQ-001 Parameter DEPTH_LOG2, default 5, event FIFO depth = 2**DEPTH_LOG2 words.
REQ-002 Parameter EMIT_BREAK, default 0, 1 = also queue break events for non-modifier keys.
REQ-003 Parameter SUPPRESS_REPEAT, default 1, 1 = drop typematic repeat makes.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 scan_valid  in  1  one-cycle strobe; scan_code holds a new received byte.
REQ-007 scan_code  in  8  PS/2 set-2 byte from the existing device-to-host receiver.
REQ-008 rd  in  1  pop head event.
REQ-009 ev_data  out  16  head event: [15]=ext, [14]=brk, [13:8]=mods, [7:0]=code.
REQ-010 empty  out  1  FIFO empty.
REQ-011 full  out  1  FIFO full.
REQ-012 overflow  out  1  sticky; an event was dropped.
REQ-013 ovf_clr  in  1  clears overflow.
REQ-014 led_state  out  3  {scroll, num, caps} lock state.
REQ-015 led_upd  out  1  one-cycle pulse when led_state changes.

Function
REQ-016 mods = {scroll, num, caps, alt, ctrl, shift}; shift = lshift|rshift, ctrl = lctrl|rctrl, alt = lalt|ralt; value captured when the event is queued.
REQ-017 Parser FSM states: IDLE, BRK, EXT, EXT_BRK, PAUSE; transitions only on scan_valid.
REQ-018 IDLE: F0->BRK; E0->EXT; E1->PAUSE (skip count 7); other byte -> key(ext=0, brk=0), stay IDLE.
REQ-019 BRK: byte -> key(ext=0, brk=1) -> IDLE. EXT: F0->EXT_BRK; other -> key(ext=1, brk=0) -> IDLE. EXT_BRK: byte -> key(ext=1, brk=1) -> IDLE.
REQ-020 PAUSE: consume 7 further bytes unconditionally; on the 7th queue {ext=1, brk=0, mods, 8'h77}; -> IDLE.
REQ-021 Modifier keys: 12=lshift, 59=rshift, 14=lctrl, E0 14=rctrl, 11=lalt, E0 11=ralt; make sets, break clears; never queued.
REQ-022 E0 12 and E0 59 (fake shifts) are ignored entirely: no state change, no event.
REQ-023 Lock keys: 58=caps, 77=num, 7E=scroll; toggle on a make that is not a repeat (REQ-024), regardless of SUPPRESS_REPEAT; never queued; each toggle pulses led_upd in the cycle after the final byte.
REQ-024 last_make (9 bits incl. ext): a make equal to last_make is a repeat; any other make loads last_make; a break matching last_make clears it to 0.
REQ-025 Non-modifier make: queued unless (repeat and SUPPRESS_REPEAT=1). Non-modifier break: queued only when EMIT_BREAK=1.
REQ-026 Latency: final byte strobed in cycle N -> FIFO write in cycle N+1 -> empty=0, ev_data valid in cycle N+2.
REQ-027 FIFO is first-word-fall-through: ev_data = head word whenever empty=0; rd with empty=0 pops at the edge; rd with empty=1 is ignored.
REQ-028 Write accepted when full=0, or when full=1 and rd is high in the same cycle; otherwise the event is dropped and overflow is set.
REQ-029 Simultaneous rd and write with 0 < count < depth: count unchanged, order preserved.
REQ-030 Pointers wrap modulo 2**DEPTH_LOG2; count is DEPTH_LOG2+1 bits; full = count==depth.
REQ-031 ovf_clr and a drop in the same cycle: overflow remains 1.
REQ-032 scan_valid with no state change (e.g. an ignored byte) leaves all outputs unchanged.

Reset
REQ-033 rst=0 asynchronously forces: FSM=IDLE, skip count=0, all modifiers and locks 0, last_make=0, FIFO count and pointers 0.
REQ-034 During reset: empty=1, full=0, overflow=0, led_state=000, led_upd=0; ev_data is don't-care.
REQ-035 Reset asserted mid-sequence (e.g. after E0) discards the partial sequence; the first byte after release is parsed from IDLE.

Verification
REQ-036 Bytes 12, 1C, 1C, F0 1C, F0 12 -> exactly one event 0x011C; with EMIT_BREAK=1 an additional event 0x411C.
REQ-037 Bytes 58, 58, F0 58 -> led_state=001, exactly one led_upd pulse; FIFO stays empty.
REQ-038 Bytes E0 12 E0 7C -> one event 0x807C; shift stays 0.
REQ-039 Bytes E1 14 77 E1 F0 14 F0 77 -> one event 0x8077; num lock unchanged.
REQ-040 DEPTH_LOG2=2: 5 distinct makes, no rd -> full=1 after 4, 5th dropped, overflow=1; ovf_clr -> 0; pops return the first 4 in order.
REQ-041 rst pulsed low after E0 -> then byte 1C -> event 0x001C; all state matches REQ-034.

Source files
------------

// File: rtl/ps2_kbd_events.sv
// PS/2 set-2 keyboard event decoder: parses scan bytes into key events
// with modifier and lock tracking, buffered in a first-word-fall-through FIFO.
module ps2_kbd_events #(
    parameter int unsigned DEPTH_LOG2      = 5,
    parameter int unsigned EMIT_BREAK      = 0,
    parameter int unsigned SUPPRESS_REPEAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_valid,
    input  logic [7:0]  scan_code,
    input  logic        rd,
    output logic [15:0] ev_data,
    output logic        empty,
    output logic        full,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [2:0]  led_state,
    output logic        led_upd
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  skip_cnt;
    logic [2:0]  skip_nxt;

    logic        key_fire;
    logic        key_ext;
    logic        key_brk;
    logic        pause_fire;

    logic [8:0]  key9;
    logic [8:0]  last_make;
    logic        is_rep;
    logic        is_lsh;
    logic        is_rsh;
    logic        is_lctl;
    logic        is_rctl;
    logic        is_lalt;
    logic        is_ralt;
    logic        is_fake;
    logic        is_mod;
    logic [2:0]  lock_hit;
    logic        is_lock;

    logic        lshift;
    logic        rshift;
    logic        lctrl;
    logic        rctrl;
    logic        lalt;
    logic        ralt;
    logic [5:0]  mods;

    logic        pend_vld;
    logic        pend_ext;
    logic        pend_brk;
    logic [7:0]  pend_code;
    logic [15:0] wr_data;

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;

    // Parser state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            skip_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    // Parser next-state: prefixes steer, everything else returns to idle.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt = S_BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_nxt = S_EXT;
                    end else if (scan_code == 8'hE1) begin
                        state_nxt = S_PAUSE;
                        skip_nxt  = 3'd7;
                    end
                end
                S_BRK: state_nxt = S_IDLE;
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt = S_EXT_BRK;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_EXT_BRK: state_nxt = S_IDLE;
                S_PAUSE: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Parser outputs: which byte completes a key and its ext/break flags.
    always_comb begin
        key_fire   = 1'b0;
        key_ext    = 1'b0;
        key_brk    = 1'b0;
        pause_fire = 1'b0;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    key_fire = (scan_code != 8'hF0) &&
                               (scan_code != 8'hE0) &&
                               (scan_code != 8'hE1);
                end
                S_BRK: begin
                    key_fire = 1'b1;
                    key_brk  = 1'b1;
                end
                S_EXT: begin
                    key_fire = (scan_code != 8'hF0);
                    key_ext  = 1'b1;
                end
                S_EXT_BRK: begin
                    key_fire = 1'b1;
                    key_ext  = 1'b1;
                    key_brk  = 1'b1;
                end
                S_PAUSE: pause_fire = (skip_cnt == 3'd1);
                default: key_fire = 1'b0;
            endcase
        end
    end

    // Key classification of the completed byte.
    always_comb begin
        key9        = {key_ext, scan_code};
        is_rep      = (key9 == last_make);
        is_lsh      = !key_ext && (scan_code == 8'h12);
        is_rsh      = !key_ext && (scan_code == 8'h59);
        is_lctl     = !key_ext && (scan_code == 8'h14);
        is_rctl     =  key_ext && (scan_code == 8'h14);
        is_lalt     = !key_ext && (scan_code == 8'h11);
        is_ralt     =  key_ext && (scan_code == 8'h11);
        is_fake     =  key_ext &&
                       ((scan_code == 8'h12) || (scan_code == 8'h59));
        is_mod      = is_lsh | is_rsh | is_lctl |
                      is_rctl | is_lalt | is_ralt;
        lock_hit[0] = !key_ext && (scan_code == 8'h58);
        lock_hit[1] = !key_ext && (scan_code == 8'h77);
        lock_hit[2] = !key_ext && (scan_code == 8'h7E);
        is_lock     = |lock_hit;
    end

    // Key state: modifiers, locks, repeat filter and the pending event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            lalt      <= 1'b0;
            ralt      <= 1'b0;
            led_state <= 3'b000;
            led_upd   <= 1'b0;
            last_make <= 9'd0;
            pend_vld  <= 1'b0;
            pend_ext  <= 1'b0;
            pend_brk  <= 1'b0;
            pend_code <= 8'h00;
        end else begin
            led_upd  <= 1'b0;
            pend_vld <= 1'b0;
            if (key_fire && !is_fake) begin
                if (!key_brk) begin
                    if (!is_rep) begin
                        last_make <= key9;
                    end
                end else if (is_rep) begin
                    last_make <= 9'd0;
                end
                if (is_mod) begin
                    if (is_lsh)  lshift <= !key_brk;
                    if (is_rsh)  rshift <= !key_brk;
                    if (is_lctl) lctrl  <= !key_brk;
                    if (is_rctl) rctrl  <= !key_brk;
                    if (is_lalt) lalt   <= !key_brk;
                    if (is_ralt) ralt   <= !key_brk;
                end else if (is_lock) begin
                    if (!key_brk && !is_rep) begin
                        led_state <= led_state ^ lock_hit;
                        led_upd   <= 1'b1;
                    end
                end else if (!key_brk) begin
                    if (!(is_rep && (SUPPRESS_REPEAT != 0))) begin
                        pend_vld  <= 1'b1;
                        pend_ext  <= 1'b1 & key_ext;
                        pend_brk  <= 1'b0;
                        pend_code <= scan_code;
                    end
                end else if (EMIT_BREAK != 0) begin
                    pend_vld  <= 1'b1;
                    pend_ext  <= key_ext;
                    pend_brk  <= 1'b1;
                    pend_code <= scan_code;
                end
            end
            if (pause_fire) begin
                pend_vld  <= 1'b1;
                pend_ext  <= 1'b1;
                pend_brk  <= 1'b0;
                pend_code <= 8'h77;
            end
        end
    end

    // Modifiers are sampled as the event enters the FIFO.
    always_comb begin
        mods    = {led_state, lalt | ralt, lctrl | rctrl, lshift | rshift};
        wr_data = {pend_ext, pend_brk, mods, pend_code};
    end

    // FIFO handshake: a full FIFO still accepts a write when it pops.
    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_CNT);
        do_pop  = rd && !empty;
        do_push = pend_vld && (!full || rd);
        drop    = pend_vld && !do_push;
        ev_data = mem[rptr];
    end

    // FIFO storage, no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_events.sv
// Scoreboard bench for ps2_kbd_events: two instances (small FIFO without
// breaks, default FIFO with breaks) driven by the same scan bytes.
module tb_ps2_kbd_events;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        ovf_clr = 1'b0;
    logic        rd0 = 1'b0;
    logic        rd1 = 1'b0;
    logic [15:0] ev0;
    logic [15:0] ev1;
    logic        empty0, empty1, full0, full1, ovf0, ovf1;
    logic [2:0]  led0, led1;
    logic        upd0, upd1;

    int errors = 0;
    int checks = 0;
    int lp0 = 0;
    int lp1 = 0;
    bit mon0_en = 1'b0;
    bit mon1_en = 1'b0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    ps2_kbd_events #(.DEPTH_LOG2(2), .EMIT_BREAK(0), .SUPPRESS_REPEAT(1)) dut0 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd(rd0), .ev_data(ev0), .empty(empty0), .full(full0),
        .overflow(ovf0), .ovf_clr(ovf_clr), .led_state(led0), .led_upd(upd0)
    );

    ps2_kbd_events #(.DEPTH_LOG2(5), .EMIT_BREAK(1), .SUPPRESS_REPEAT(1)) dut1 (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
        .rd(rd1), .ev_data(ev1), .empty(empty1), .full(full1),
        .overflow(ovf1), .ovf_clr(ovf_clr), .led_state(led1), .led_upd(upd1)
    );

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor for dut0: pop and compare whenever an event is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (mon0_en && rst && !empty0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL ev0 unexpected: got %h want none", ev0);
                end else begin
                    logic [15:0] e;
                    e = q0.pop_front();
                    if (ev0 !== e) begin
                        errors++;
                        $display("FAIL ev0: got %h want %h", ev0, e);
                    end
                end
                rd0 = 1'b1;
            end else begin
                rd0 = 1'b0;
            end
        end
    end

    // Monitor for dut1.
    initial begin
        forever begin
            @(negedge clk);
            if (mon1_en && rst && !empty1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL ev1 unexpected: got %h want none", ev1);
                end else begin
                    logic [15:0] e;
                    e = q1.pop_front();
                    if (ev1 !== e) begin
                        errors++;
                        $display("FAIL ev1: got %h want %h", ev1, e);
                    end
                end
                rd1 = 1'b1;
            end else begin
                rd1 = 1'b0;
            end
        end
    end

    // LED update pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (upd0) lp0++;
            if (upd1) lp1++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic exp_both(input logic [15:0] e);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !empty0 || !empty1)
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain %s: got q0=%0d q1=%0d want 0", name,
                     q0.size(), q1.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_empty0", empty0, 1'b1);
        chk("rst_empty1", empty1, 1'b1);
        chk("rst_full0", full0, 1'b0);
        chk("rst_ovf0", ovf0, 1'b0);
        chk("rst_ovf1", ovf1, 1'b0);
        chk("rst_led0", led0, 3'b000);
        chk("rst_led1", led1, 3'b000);
        chk("rst_upd0", upd0, 1'b0);
        lp0 = 0;
        lp1 = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        mon0_en = 1'b1;
        mon1_en = 1'b1;

        // Shifted make, repeat suppressed, break only on dut1.
        exp_both(16'h011C);
        q1.push_back(16'h411C);
        send(8'h12); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        drain("shift");

        // Fake shift ignored, extended make.
        exp_both(16'h807C);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        drain("fake");

        // Extended break on dut1 only.
        q1.push_back(16'hC07C);
        send(8'hE0); send(8'hF0); send(8'h7C);
        drain("extbrk");

        // Pause sequence.
        exp_both(16'h8077);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain("pause");
        chk("pause_led0", led0, 3'b000);

        // Right ctrl + left alt, then release and make again.
        exp_both(16'h062B);
        q1.push_back(16'h462B);
        exp_both(16'h002B);
        send(8'hE0); send(8'h14); send(8'h11); send(8'h2B);
        send(8'hF0); send(8'h2B);
        send(8'hE0); send(8'hF0); send(8'h14);
        send(8'hF0); send(8'h11); send(8'h2B);
        drain("ctrlalt");

        // Caps lock toggle with a repeat, then num and scroll.
        do_reset();
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        repeat (3) @(negedge clk);
        chk("caps_led0", led0, 3'b001);
        chk("caps_led1", led1, 3'b001);
        chk("caps_pulses0", 16'(lp0), 16'd1);
        chk("caps_pulses1", 16'(lp1), 16'd1);
        chk("caps_empty0", empty0, 1'b1);
        exp_both(16'h381C);
        send(8'h77); send(8'h7E); send(8'h1C);
        drain("locks");
        chk("locks_led0", led0, 3'b111);
        chk("locks_pulses0", 16'(lp0), 16'd3);

        // Overflow on the 4-deep instance.
        do_reset();
        mon0_en = 1'b0;
        exp_both(16'h0015);
        exp_both(16'h001D);
        exp_both(16'h0024);
        exp_both(16'h002D);
        q1.push_back(16'h002C);
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        @(negedge clk);
        chk("full_at4", full0, 1'b1);
        chk("ovf_at4", ovf0, 1'b0);
        send(8'h2C);
        repeat (2) @(negedge clk);
        chk("ovf_drop", ovf0, 1'b1);
        chk("full_drop", full0, 1'b1);
        chk("ovf_dut1", ovf1, 1'b0);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr", ovf0, 1'b0);

        // Drop in the same cycle as ovf_clr keeps the flag set.
        q1.push_back(16'h0035);
        @(negedge clk);
        scan_code  = 8'h35;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        ovf_clr    = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr_drop", ovf0, 1'b1);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("ovf_clr2", ovf0, 1'b0);

        // Write into a full FIFO while it pops.
        exp_both(16'h003C);
        exp_both(16'h0043);
        @(negedge clk);
        scan_code  = 8'h3C;
        scan_valid = 1'b1;
        @(posedge clk);
        mon0_en = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        send(8'h43);
        drain("fullrd");
        chk("ovf_fullrd", ovf0, 1'b0);

        // Reset after E0 discards the prefix; check write latency.
        send(8'hE0);
        do_reset();
        mon0_en = 1'b0;
        mon1_en = 1'b0;
        exp_both(16'h001C);
        @(negedge clk);
        scan_code  = 8'h1C;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        chk("lat_n1_empty0", empty0, 1'b1);
        @(negedge clk);
        chk("lat_n2_empty0", empty0, 1'b0);
        chk("lat_n2_empty1", empty1, 1'b0);
        mon0_en = 1'b1;
        mon1_en = 1'b1;
        drain("rstmid");
        chk("end_led0", led0, 3'b000);
        chk("end_full0", full0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
